scoreboard: RTL

//  Parametrised in-order issue / out-of-order writeback / in-order commit buffer of scoreboard_entry.

---
 rtl/scoreboard.sv | 115 +++++++++++
 1 files changed

// File: rtl/scoreboard.sv
// Issue/writeback/commit buffer: in-order issue, out-of-order writeback, in-order commit.
// Entries carry their result and any exception reported by the functional unit.
package scoreboard_pkg;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [3:0]  fu;
        logic [6:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] result;
        logic        valid;
        logic        use_imm;
        exception_t  ex;
    } scoreboard_entry_t;

endpackage

module scoreboard
    import scoreboard_pkg::*;
#(
    parameter int unsigned  NR_ENTRIES    = 8,
    parameter int unsigned  NR_WB_PORTS   = 2,
    localparam int unsigned TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    output logic                     full_o,
    input  scoreboard_entry_t        issue_instr_i,
    input  logic                     issue_valid_i,
    output logic                     issue_ack_o,
    output logic [TRANS_ID_BITS-1:0] issue_trans_id_o,
    output scoreboard_entry_t        commit_instr_o,
    output logic                     commit_valid_o,
    input  logic                     commit_ack_i,
    input  logic [TRANS_ID_BITS-1:0] wb_trans_id_i [NR_WB_PORTS],
    input  logic [63:0]              wb_data_i     [NR_WB_PORTS],
    input  exception_t               wb_ex_i       [NR_WB_PORTS],
    input  logic [NR_WB_PORTS-1:0]   wb_valid_i
);

    localparam int unsigned CNT_BITS = TRANS_ID_BITS + 1;

    scoreboard_entry_t          mem_q [NR_ENTRIES];
    logic [NR_ENTRIES-1:0]      occ_q;
    logic [TRANS_ID_BITS-1:0]   head_q;
    logic [TRANS_ID_BITS-1:0]   tail_q;
    logic [CNT_BITS-1:0]        count_q;
    logic                       commit_pop;

    // Handshakes are combinational views of registered state
    assign full_o           = (count_q == CNT_BITS'(NR_ENTRIES));
    assign issue_ack_o      = issue_valid_i & ~full_o & ~flush_i;
    assign issue_trans_id_o = tail_q;
    assign commit_instr_o   = mem_q[head_q];
    assign commit_valid_o   = occ_q[head_q] & mem_q[head_q].valid;
    assign commit_pop       = commit_ack_i & commit_valid_o & ~flush_i;

    // Entry storage: issue fills the tail slot, writeback only lands on occupied slots.
    // Later assignments win, so the highest writeback port overrides lower ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (!flush_i) begin
            if (issue_ack_o) begin
                mem_q[tail_q]          <= issue_instr_i;
                mem_q[tail_q].valid    <= 1'b0;
                mem_q[tail_q].ex.valid <= 1'b0;
            end
            for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
                if (wb_valid_i[p] && occ_q[wb_trans_id_i[p]]) begin
                    mem_q[wb_trans_id_i[p]].result <= wb_data_i[p];
                    mem_q[wb_trans_id_i[p]].valid  <= 1'b1;
                    mem_q[wb_trans_id_i[p]].ex     <= wb_ex_i[p];
                end
            end
        end
    end

    // Occupancy, pointers and fill level; flush returns everything to empty
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            occ_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (issue_ack_o) begin
                occ_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + TRANS_ID_BITS'(1);
            end
            if (commit_pop) begin
                occ_q[head_q] <= 1'b0;
                head_q        <= head_q + TRANS_ID_BITS'(1);
            end
            count_q <= count_q + CNT_BITS'(issue_ack_o) - CNT_BITS'(commit_pop);
        end
    end

endmodule
